maxpool_mul_pipe: RTL
=====================

// Module: maxpool_mul_pipe
// PURPOSE
//  Parametrised pipelined integer multiplier for the max-pool/CIF datapath (index and
//  address scaling, fixed-point weights). Generalises the fixed 2-stage unsigned
//  multiplier: configurable operand/result widths and depth, per-operand signed mode,
//  and a valid bit carried alongside the data so consumers need not count cycles.
// PARAMETERS
//  DIN0_WIDTH  32  width of operand 0
//  DIN1_WIDTH  31  width of operand 1
//  DOUT_WIDTH  63  result width; legal range 1..DIN0_WIDTH+DIN1_WIDTH+2
//  NUM_STAGE   2   pipeline depth in ce-enabled cycles; legal range 1..8
// PORTS
//  clk        in   1           rising-edge clock; sole clock of the block
//  reset      in   1           synchronous, active-high reset
//  ce         in   1           clock enable; 0 freezes every pipeline register
//  in_valid   in   1           operands and mode bits on this cycle are a transaction
//  din0       in   DIN0_WIDTH  operand 0
//  din1       in   DIN1_WIDTH  operand 1
//  din0_sgn   in   1           1: din0 is two's complement; 0: unsigned
//  din1_sgn   in   1           1: din1 is two's complement; 0: unsigned
//  out_valid  out  1           dout holds the result of a transaction
//  dout       out  DOUT_WIDTH  product
// BEHAVIOUR
//  - Reset: on a clk edge with reset=1, all stage registers clear: dout=0, out_valid=0.
//    Reset overrides ce, so it takes effect even when ce=0. In-flight transactions are
//    discarded; no output appears for them after reset.
//  - Arithmetic: each operand is extended by one bit (sign bit if its *_sgn=1, zero
//    otherwise), then multiplied as signed. Full product width P=DIN0_WIDTH+DIN1_WIDTH+2.
//    dout = P[DOUT_WIDTH-1:0]. Results are truncated, never saturated.
//  - Mode bits are sampled with their operands. Mixed signedness is legal per
//    transaction. Back-to-back transactions with different modes must not interact.
//  - Pipeline: a NUM_STAGE-deep shift of {valid,data}.
//      Stage 1 registers the extended operands and in_valid.
//      The product is formed between stage 1 and stage 2; remaining stages are delay.
//      NUM_STAGE=1 registers the product directly from the inputs.
//    A transaction presented on ce=1 edge k appears on dout/out_valid after the edge
//    at which ce=1 for the NUM_STAGE-th time (counting edge k). Throughput is 1 per
//    ce-enabled cycle.
//  - ce=0: no register changes. dout and out_valid hold, and inputs are ignored.
//  - in_valid=0 with ce=1: a bubble advances. out_valid=0 at that slot. dout data in
//    the bubble slot is don't-care, but the bench checks dout only when out_valid=1.
//  - reset=1 and ce=1 with in_valid=1 on the same edge: reset wins; the transaction is
//    dropped.
//  - No backpressure: the consumer must accept every out_valid=1 cycle, or drive ce=0
//    to stall the whole pipe.
// TESTING
//  1 Unsigned max, defaults: din0=0xFFFFFFFF, din1=0x7FFFFFFF, sgn=00, ce=1
//    -> 2 edges later out_valid=1, dout=0x7FFFFFFE80000001.
//  2 Mixed sign: din0=0xFFFFFFFF, din0_sgn=1; din1=3, din1_sgn=0
//    -> dout=0x7FFFFFFFFFFFFFFD (-3 truncated to 63 b).
//  3 Stream of 10 back-to-back transactions with alternating modes, ce=1 throughout
//    -> 10 consecutive out_valid=1 cycles; each dout matches the reference model.
//  4 Issue A=5*7, then ce=0 for 3 cycles, then ce=1 -> dout/out_valid frozen during the
//    stall; dout=35 appears exactly at the 2nd ce-enabled edge; no duplicate valid.
//  5 Reset with 2 transactions in flight (reset=1 for 1 cycle, ce=0 that cycle)
//    -> out_valid=0 and dout=0 next cycle; neither transaction ever emerges.
//  6 NUM_STAGE=1 and NUM_STAGE=4, DIN0/1_WIDTH=8, DOUT_WIDTH=8, signed -128*-128
//    -> dout=0x00 (truncation of 16384), with latency 1 and 4 respectively.

Source files
------------

// File: rtl/maxpool_mul_pipe.sv
// Parametrised pipelined integer multiplier with per-operand signed mode and a
// valid bit that travels with the data through every stage.
module maxpool_mul_pipe #(
    parameter int unsigned DIN0_WIDTH = 32,
    parameter int unsigned DIN1_WIDTH = 31,
    parameter int unsigned DOUT_WIDTH = 63,
    parameter int unsigned NUM_STAGE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  din0_sgn,
    input  logic                  din1_sgn,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int unsigned A_W = DIN0_WIDTH + 1;
    localparam int unsigned B_W = DIN1_WIDTH + 1;
    localparam int unsigned P_W = A_W + B_W;
    // Stages after the product; NUM_STAGE=1 still needs one output register.
    localparam int unsigned DLY = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    logic [A_W-1:0]        a_c;
    logic [B_W-1:0]        b_c;
    logic [A_W-1:0]        mul_a;
    logic [B_W-1:0]        mul_b;
    logic                  mul_v;
    logic [P_W-1:0]        mul_a_x;
    logic [P_W-1:0]        mul_b_x;
    logic [DOUT_WIDTH-1:0] prod_t;
    logic [DOUT_WIDTH-1:0] dly_d [DLY];
    logic [DLY-1:0]        dly_v;

    // One-bit operand extension: sign bit in signed mode, zero otherwise.
    always_comb begin
        a_c = {din0_sgn & din0[DIN0_WIDTH-1], din0};
        b_c = {din1_sgn & din1[DIN1_WIDTH-1], din1};
    end

    generate
        if (NUM_STAGE == 1) begin : g_direct
            // Product is formed straight from the inputs.
            always_comb begin
                mul_a = a_c;
                mul_b = b_c;
                mul_v = in_valid;
            end
        end else begin : g_stage1
            logic [A_W-1:0] a_q;
            logic [B_W-1:0] b_q;
            logic           v_q;

            // Stage 1: register extended operands and their valid bit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                    v_q <= 1'b0;
                end else if (ce) begin
                    a_q <= a_c;
                    b_q <= b_c;
                    v_q <= in_valid;
                end
            end

            // Multiplier operands come from stage 1.
            always_comb begin
                mul_a = a_q;
                mul_b = b_q;
                mul_v = v_q;
            end
        end
    endgenerate

    // Sign-extend to full product width; the low P_W bits of an unsigned
    // multiply of sign-extended values equal the signed product.
    always_comb begin
        mul_a_x = {{B_W{mul_a[A_W-1]}}, mul_a};
        mul_b_x = {{A_W{mul_b[B_W-1]}}, mul_b};
        prod_t  = DOUT_WIDTH'(mul_a_x * mul_b_x);
    end

    // Product register followed by pure delay stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DLY); i++) begin
                dly_d[i] <= '0;
            end
            dly_v <= '0;
        end else if (ce) begin
            dly_d[0] <= prod_t;
            dly_v[0] <= mul_v;
            for (int i = 1; i < int'(DLY); i++) begin
                dly_d[i] <= dly_d[i-1];
                dly_v[i] <= dly_v[i-1];
            end
        end
    end

    // Outputs come directly from the last stage registers.
    always_comb begin
        out_valid = dly_v[DLY-1];
        dout      = dly_d[DLY-1];
    end

endmodule
